hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//   Parametrised hazard and forwarding controller for the pipelined RISC-V core, successor to the fixed two-stage forwarding logic.
//   Selects an N-stage bypass for each E-stage source, generates load-use stalls and branch flushes, and scoreboards one
//   outstanding multicycle op (mul/div) with a latency counter and a writeback-slot grant. Sits beside the datapath, driving the F/D/E controls.
// PARAMETERS
//   RA_W     5  register address width; x0 is never forwarded or scoreboarded
//   NUM_SRC  2  source operands per instruction (3 for fused ops)
//   NUM_FWD  2  forwarding stages after E; index 0 = youngest (M), NUM_FWD-1 = W
//   MC_LAT   4  multicycle unit latency in cycles from issue to result ready (>=2)
//   SEL_W    $clog2(NUM_FWD+1)  derived width of each forward select
// PORTS
//   clk          in   1              rising-edge clock
//   reset_n      in   1              asynchronous active-low reset
//   rs_d         in   NUM_SRC*RA_W   D-stage sources, src s at [s*RA_W +: RA_W]
//   mc_op_d      in   1              D-stage instruction is multicycle
//   rs_e         in   NUM_SRC*RA_W   E-stage sources
//   rd_e         in   RA_W           E-stage destination
//   regwrite_e   in   1              E-stage writes rd_e
//   load_e       in   1              E-stage instruction is a load
//   mc_issue_e   in   1              E-stage multicycle op issues this cycle (dest rd_e)
//   pc_src_e     in   1              branch/jump taken in E
//   rd_stg       in   NUM_FWD*RA_W   destinations of stages M..W
//   regwrite_stg in   NUM_FWD        write enables of stages M..W
//   fwd_sel      out  NUM_SRC*SEL_W  per source: 0 = regfile, k = stage k-1
//   stall_f      out  1              hold PC
//   stall_d      out  1              hold F/D register
//   flush_d      out  1              clear F/D register
//   flush_e      out  1              clear D/E register (bubble)
//   mc_busy      out  1              scoreboard entry valid
//   mc_wb        out  1              one-cycle grant: multicycle result takes W write port this cycle
//   mc_rd        out  RA_W           scoreboarded destination register
// BEHAVIOUR
//   Reset (async on reset_n low): sb_valid=0, cnt=0, mc_rd=0, mc_wb=0. All combinational outputs evaluate to 0.
//   Forwarding (comb): fwd_sel[s] = smallest k in 1..NUM_FWD such that regwrite_stg[k-1] && rd_stg[k-1]==rs_e[s] && rs_e[s]!=0.
//     Otherwise 0. The youngest stage wins on multiple matches.
//   lu_hz = load_e && regwrite_e && rd_e!=0 && any rs_d[s]==rd_e.
//   sb_hz = sb_valid && mc_rd!=0 && any rs_d[s]==mc_rd  (RAW on the pending multicycle result).
//   st_hz = mc_op_d && (sb_valid || mc_issue_e)  (structural: one op outstanding).
//   hz = lu_hz | sb_hz | st_hz.
//   stall_f = stall_d = hz && !pc_src_e.
//   flush_e = hz | pc_src_e. flush_d = pc_src_e. A taken branch overrides every stall.
//   Scoreboard FSM, states IDLE -> COUNT -> WAIT_WB -> IDLE:
//     IDLE:    mc_issue_e -> load mc_rd=rd_e, cnt=MC_LAT-1, sb_valid=1, go to COUNT. Issue is accepted even when pc_src_e=1 (E is older).
//     COUNT:   cnt decrements each cycle; at cnt==0 go to WAIT_WB.
//     WAIT_WB: mc_wb=1 in any cycle where regwrite_stg[NUM_FWD-1]==0 (W port free), then clear sb_valid and go to IDLE.
//              Otherwise hold; each held cycle adds latency.
//   sb_hz stays asserted in the mc_wb cycle. The dependent instruction leaves D on the next cycle and reads the regfile,
//     which writes in the first half-cycle.
//   mc_issue_e while sb_valid is a protocol violation. It is ignored (state unchanged) and flagged by a simulation assertion.
//   reset_n deasserted mid-operation discards the pending op, mc_wb is never emitted, and stalls release immediately.
//   mc_rd == 0: scoreboarded as normal, but sb_hz is never raised; mc_wb is still granted.
// STRUCTURE
//   hazard_pkg: SEL_RF=0 constant, the FSM state enum {IDLE, COUNT, WAIT_WB}, and a function returning src s of a packed vector.
//   fwd_select sub-module (one comparator chain and priority encoder per source), generate-instantiated NUM_SRC times.
//   Hazard detection and the scoreboard FSM remain in the top level.
// TESTING
//   1. rs_e[0]=5, rd_stg={M:5,W:5}, both regwrite -> fwd_sel[0]=1; clear M regwrite -> 2; rs_e[0]=0 -> 0.
//   2. load_e=1, rd_e=7, rs_d[1]=7 -> one cycle stall_f=stall_d=flush_e=1, flush_d=0; the next cycle is clean.
//   3. Same as 2 plus pc_src_e=1 -> stall_f=stall_d=0, flush_d=flush_e=1.
//   4. MC_LAT=4, mc_issue_e with rd_e=9, and the consumer with rs_d=9 arriving next cycle -> mc_busy for 4 cycles,
//      mc_wb pulses in cycle 4 after issue, and the stall is released in cycle 5.
//   5. Issue as in 4 with regwrite_stg[W]=1 for 2 extra cycles at cnt==0 -> mc_wb is delayed 2 cycles and the stall is extended.
//   6. mc_op_d=1 while busy -> structural stall until mc_wb; assert reset_n=0 mid-COUNT -> mc_busy=0 and the stall drops at once.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared constants, scoreboard state encoding and a field extractor for the
// hazard/forwarding controller.
package hazard_ctrl_unit_pkg;

    localparam int unsigned SEL_RF  = 0;
    localparam int unsigned VEC_MAX = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        WAIT_WB = 2'd2
    } sb_state_e;

    // Returns field s (w bits wide) of a packed vector of equal-width fields.
    function automatic logic [31:0] get_src(input logic [VEC_MAX-1:0] vec,
                                            input int unsigned         s,
                                            input int unsigned         w);
        logic [VEC_MAX-1:0] shifted;
        shifted = vec >> (s * w);
        return shifted[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Datapath <-> hazard controller signal bundle; the datapath is the master,
// the controller the slave.
interface hazard_ctrl_unit_if #(
    parameter int RA_W    = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) ();
    logic [NUM_SRC*RA_W-1:0]  rs_d;
    logic                     mc_op_d;
    logic [NUM_SRC*RA_W-1:0]  rs_e;
    logic [RA_W-1:0]          rd_e;
    logic                     regwrite_e;
    logic                     load_e;
    logic                     mc_issue_e;
    logic                     pc_src_e;
    logic [NUM_FWD*RA_W-1:0]  rd_stg;
    logic [NUM_FWD-1:0]       regwrite_stg;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall_f;
    logic                     stall_d;
    logic                     flush_d;
    logic                     flush_e;
    logic                     mc_busy;
    logic                     mc_wb;
    logic [RA_W-1:0]          mc_rd;

    modport master (
        output rs_d, mc_op_d, rs_e, rd_e, regwrite_e, load_e, mc_issue_e,
               pc_src_e, rd_stg, regwrite_stg,
        input  fwd_sel, stall_f, stall_d, flush_d, flush_e, mc_busy, mc_wb, mc_rd
    );

    modport slave (
        input  rs_d, mc_op_d, rs_e, rd_e, regwrite_e, load_e, mc_issue_e,
               pc_src_e, rd_stg, regwrite_stg,
        output fwd_sel, stall_f, stall_d, flush_d, flush_e, mc_busy, mc_wb, mc_rd
    );
endinterface

// File: rtl/hazard_ctrl_unit_chk.sv
// Protocol checker: a multicycle op must not issue while one is outstanding.
module hazard_ctrl_unit_chk (
    input logic clk,
    input logic reset_n,
    input logic mc_issue_e,
    input logic sb_valid
);

    a_issue_while_busy: assert property (@(posedge clk) disable iff (!reset_n)
        !(mc_issue_e && sb_valid))
        else $error("protocol violation: mc_issue_e while scoreboard busy");

endmodule

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Bypass selector for one E-stage source: picks the youngest writing stage
// whose destination matches; x0 never forwards.
module fwd_select
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic [RA_W-1:0]         rs_i,
    input  logic [NUM_FWD*RA_W-1:0] rd_stg_i,
    input  logic [NUM_FWD-1:0]      regwrite_stg_i,
    output logic [SEL_W-1:0]        sel_o
);

    logic [NUM_FWD-1:0] hit_s;

    // Per-stage comparators
    always_comb begin
        hit_s = {NUM_FWD{1'b0}};
        for (int k = 0; k < NUM_FWD; k++) begin
            hit_s[k] = regwrite_stg_i[k]
                     && (rd_stg_i[k*RA_W +: RA_W] == rs_i)
                     && (rs_i != {RA_W{1'b0}});
        end
    end

    // Priority encoder, scanning oldest to youngest so the youngest hit wins
    always_comb begin
        sel_o = SEL_W'(SEL_RF);
        for (int k = NUM_FWD; k >= 1; k--) begin
            sel_o = hit_s[k-1] ? SEL_W'(k) : sel_o;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller: N-stage bypass select, load-use / RAW /
// structural stalls, branch flushes and a one-entry multicycle scoreboard.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int MC_LAT  = 4,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input logic               clk,
    input logic               reset_n,
    hazard_ctrl_unit_if.slave bus
);

    localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    sb_state_e                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [RA_W-1:0]          mc_rd_q, mc_rd_d;
    logic                     mc_wb_s;
    logic                     sb_valid_s;
    logic                     lu_match_s, sb_match_s;
    logic                     lu_hz_s, sb_hz_s, st_hz_s, hz_s;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        fwd_select #(.RA_W(RA_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_select (
            .rs_i           (bus.rs_e[g*RA_W +: RA_W]),
            .rd_stg_i       (bus.rd_stg),
            .regwrite_stg_i (bus.regwrite_stg),
            .sel_o          (fwd_sel_s[g*SEL_W +: SEL_W])
        );
    end

    // D-stage source matches against the E-stage load and the pending multicycle result
    always_comb begin
        logic [RA_W-1:0] src;
        src        = {RA_W{1'b0}};
        lu_match_s = 1'b0;
        sb_match_s = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src        = RA_W'(get_src(VEC_MAX'(bus.rs_d), unsigned'(s), unsigned'(RA_W)));
            lu_match_s = lu_match_s | (src == bus.rd_e);
            sb_match_s = sb_match_s | (src == mc_rd_q);
        end
    end

    assign sb_valid_s = (state_q != IDLE);
    assign lu_hz_s    = bus.load_e && bus.regwrite_e && (bus.rd_e != {RA_W{1'b0}}) && lu_match_s;
    assign sb_hz_s    = sb_valid_s && (mc_rd_q != {RA_W{1'b0}}) && sb_match_s;
    assign st_hz_s    = bus.mc_op_d && (sb_valid_s || bus.mc_issue_e);
    assign hz_s       = lu_hz_s || sb_hz_s || st_hz_s;

    // A taken branch in E overrides every stall; everything is quiet in reset.
    assign bus.fwd_sel = reset_n ? fwd_sel_s : {(NUM_SRC*SEL_W){1'b0}};
    assign bus.stall_f = reset_n && hz_s && !bus.pc_src_e;
    assign bus.stall_d = reset_n && hz_s && !bus.pc_src_e;
    assign bus.flush_d = reset_n && bus.pc_src_e;
    assign bus.flush_e = reset_n && (hz_s || bus.pc_src_e);
    assign bus.mc_busy = sb_valid_s;
    assign bus.mc_wb   = reset_n && mc_wb_s;
    assign bus.mc_rd   = mc_rd_q;

    // Scoreboard state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            mc_rd_q <= {RA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_rd_q <= mc_rd_d;
        end
    end

    // Scoreboard next state; an issue while busy is simply ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_rd_d = mc_rd_q;
        mc_wb_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mc_issue_e) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(MC_LAT - 1);
                    mc_rd_d = bus.rd_e;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == {CNT_W{1'b0}}) begin
                    state_d = WAIT_WB;
                end else begin
                    state_d = COUNT;
                end
            end
            WAIT_WB: begin
                if (!bus.regwrite_stg[NUM_FWD-1]) begin
                    mc_wb_s = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_WB;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    hazard_ctrl_unit_chk u_chk (
        .clk        (clk),
        .reset_n    (reset_n),
        .mc_issue_e (bus.mc_issue_e),
        .sb_valid   (sb_valid_s)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding, load-use, branch override,
// multicycle scoreboard timing, structural stall and mid-op reset.
module tb_hazard_ctrl_unit;

    localparam int RA_W    = 5;
    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int MC_LAT  = 4;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    hazard_ctrl_unit_if #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD)) hif ();

    hazard_ctrl_unit #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .MC_LAT(MC_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {stall_f, stall_d, flush_d, flush_e}
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}, {28'd0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        reset_n          = 1'b0;
        hif.rs_d         = 10'd0;
        hif.mc_op_d      = 1'b0;
        hif.rs_e         = 10'd0;
        hif.rd_e         = 5'd0;
        hif.regwrite_e   = 1'b0;
        hif.load_e       = 1'b0;
        hif.mc_issue_e   = 1'b0;
        hif.pc_src_e     = 1'b0;
        hif.rd_stg       = 10'd0;
        hif.regwrite_stg = 2'b00;

        // Reset state
        sample();
        check("rst_fwd", 32'(hif.fwd_sel), 32'd0);
        check_ctl("rst_ctl", 4'b0000);
        check("rst_busy", 32'(hif.mc_busy), 32'd0);
        check("rst_wb", 32'(hif.mc_wb), 32'd0);
        check("rst_rd", 32'(hif.mc_rd), 32'd0);
        next_cycle();
        reset_n = 1'b1;

        // Forwarding: youngest wins, fall back to W, x0 never forwarded
        hif.rs_e = {5'd0, 5'd5}; hif.rd_stg = {5'd5, 5'd5}; hif.regwrite_stg = 2'b11;
        sample(); check("fwd_m", 32'(hif.fwd_sel), 32'h1);
        next_cycle(); hif.regwrite_stg = 2'b10;
        sample(); check("fwd_w", 32'(hif.fwd_sel), 32'h2);
        next_cycle(); hif.rs_e = 10'd0; hif.rd_stg = 10'd0; hif.regwrite_stg = 2'b11;
        sample(); check("fwd_x0", 32'(hif.fwd_sel), 32'h0);
        next_cycle(); hif.rs_e = {5'd6, 5'd6}; hif.rd_stg = {5'd6, 5'd6};
        sample(); check("fwd_both", 32'(hif.fwd_sel), 32'h5);
        next_cycle(); hif.regwrite_stg = 2'b00;
        sample(); check("fwd_nowr", 32'(hif.fwd_sel), 32'h0);
        next_cycle(); hif.rs_e = 10'd0; hif.rd_stg = 10'd0;

        // Load-use: one stall cycle, then clean
        hif.load_e = 1'b1; hif.regwrite_e = 1'b1; hif.rd_e = 5'd7; hif.rs_d = {5'd7, 5'd0};
        sample(); check_ctl("lu_stall", 4'b1101);
        next_cycle(); hif.load_e = 1'b0; hif.regwrite_e = 1'b0; hif.rd_e = 5'd0;
        sample(); check_ctl("lu_clean", 4'b0000);
        // Load-use plus taken branch: branch wins
        next_cycle(); hif.load_e = 1'b1; hif.regwrite_e = 1'b1; hif.rd_e = 5'd7; hif.pc_src_e = 1'b1;
        sample(); check_ctl("lu_branch", 4'b0011);
        // Load to x0 never stalls
        next_cycle(); hif.pc_src_e = 1'b0; hif.rd_e = 5'd0; hif.rs_d = 10'd0;
        sample(); check_ctl("lu_x0", 4'b0000);
        next_cycle(); hif.load_e = 1'b0; hif.regwrite_e = 1'b0;

        // Multicycle RAW: issue rd=9, consumer rs_d=9 in D from the next cycle
        hif.mc_issue_e = 1'b1; hif.rd_e = 5'd9; hif.regwrite_e = 1'b1;
        sample(); check("mc4_busy0", 32'(hif.mc_busy), 32'd0);
        next_cycle(); hif.mc_issue_e = 1'b0; hif.rd_e = 5'd0; hif.regwrite_e = 1'b0; hif.rs_d = {5'd0, 5'd9};
        for (int c = 1; c <= 3; c++) begin
            sample();
            check($sformatf("mc4_busy_c%0d", c), 32'(hif.mc_busy), 32'd1);
            check_ctl($sformatf("mc4_stall_c%0d", c), 4'b1101);
            check($sformatf("mc4_wb_c%0d", c), 32'(hif.mc_wb), 32'd0);
            next_cycle();
        end
        sample();
        check("mc4_rd", 32'(hif.mc_rd), 32'd9);
        check("mc4_wb_c4", 32'(hif.mc_wb), 32'd1);
        check_ctl("mc4_stall_c4", 4'b1101);
        next_cycle();
        sample();
        check("mc4_busy_c5", 32'(hif.mc_busy), 32'd0);
        check("mc4_wb_c5", 32'(hif.mc_wb), 32'd0);
        check_ctl("mc4_stall_c5", 4'b0000);
        next_cycle(); hif.rs_d = 10'd0;

        // W port busy for two cycles at count end delays the grant
        hif.mc_issue_e = 1'b1; hif.rd_e = 5'd10;
        next_cycle(); hif.mc_issue_e = 1'b0; hif.rd_e = 5'd0; hif.rs_d = {5'd10, 5'd0};
        next_cycle(); next_cycle(); next_cycle();
        hif.regwrite_stg = 2'b10;
        sample(); check("mc5_wb_c4", 32'(hif.mc_wb), 32'd0);
        next_cycle();
        sample(); check("mc5_wb_c5", 32'(hif.mc_wb), 32'd0);
        check_ctl("mc5_stall_c5", 4'b1101);
        next_cycle(); hif.regwrite_stg = 2'b00;
        sample(); check("mc5_wb_c6", 32'(hif.mc_wb), 32'd1);
        check_ctl("mc5_stall_c6", 4'b1101);
        next_cycle();
        sample(); check_ctl("mc5_stall_c7", 4'b0000);
        check("mc5_busy_c7", 32'(hif.mc_busy), 32'd0);
        next_cycle(); hif.rs_d = 10'd0;

        // x0 destination with a simultaneous taken branch: no RAW stall, grant still given
        hif.mc_issue_e = 1'b1; hif.rd_e = 5'd0; hif.pc_src_e = 1'b1;
        sample(); check_ctl("mc0_branch", 4'b0011);
        next_cycle(); hif.mc_issue_e = 1'b0; hif.pc_src_e = 1'b0;
        sample(); check("mc0_busy", 32'(hif.mc_busy), 32'd1);
        check_ctl("mc0_nostall", 4'b0000);
        next_cycle(); next_cycle(); next_cycle();
        sample(); check("mc0_wb", 32'(hif.mc_wb), 32'd1);
        check_ctl("mc0_nostall_wb", 4'b0000);
        next_cycle();

        // Structural stall: second multicycle op in D, held until the grant cycle
        hif.mc_issue_e = 1'b1; hif.rd_e = 5'd3; hif.mc_op_d = 1'b1;
        sample(); check_ctl("st_issue", 4'b1101);
        next_cycle(); hif.mc_issue_e = 1'b0; hif.rd_e = 5'd0;
        next_cycle();
        sample(); check_ctl("st_c2", 4'b1101);
        next_cycle(); next_cycle();
        sample(); check("st_wb", 32'(hif.mc_wb), 32'd1);
        check_ctl("st_c4", 4'b1101);
        next_cycle();
        sample(); check_ctl("st_c5", 4'b0000);
        next_cycle(); hif.mc_op_d = 1'b0;

        // Reset mid-COUNT: op discarded, stall drops at once, no grant afterwards
        hif.mc_issue_e = 1'b1; hif.rd_e = 5'd3; hif.mc_op_d = 1'b1;
        next_cycle(); hif.mc_issue_e = 1'b0; hif.rd_e = 5'd0; hif.rs_d = {5'd0, 5'd3};
        sample(); check_ctl("rst_mid_pre", 4'b1101);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(hif.mc_busy), 32'd0);
        check_ctl("rst_mid_ctl", 4'b0000);
        check("rst_mid_rd", 32'(hif.mc_rd), 32'd0);
        next_cycle(); reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sample();
            check($sformatf("rst_after_wb%0d", c), 32'(hif.mc_wb), 32'd0);
            check_ctl($sformatf("rst_after_ctl%0d", c), 4'b0000);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
